// File: rtl/llc_fifo_reader.sv
// Pop-side drain engine for the LLC FIFOs: pops head words into a small buffer and presents them on a registered valid/ready channel.
// Define LLC_RD_SKID_EN for a 2-entry skid buffer (one word per cycle); otherwise a single entry is used.
module llc_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occupancy_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

`ifdef LLC_RD_SKID_EN
  localparam logic [1:0] CAP = 2'd2;
`else
  localparam logic [1:0] CAP = 2'd1;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [CNT_WIDTH-1:0]  xfer_q;
  logic                  pop;
  logic                  hs;

  // Pop depends only on FIFO state, flush and local occupancy, never on out_ready_i.
  assign pop = ~fifo_empty_i & ~flush_i & (state_q < CAP);
  assign hs  = valid_q & out_ready_i;

  // Entries shift toward head_q so the output word is always a plain register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      xfer_q  <= '0;
    end else begin
      if (hs) xfer_q <= xfer_q + 1'b1;
      if (flush_i) begin
        state_q <= EMPTY;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (pop) begin
              head_q  <= fifo_data_i;
              state_q <= ONE;
              valid_q <= 1'b1;
            end
          end
          ONE: begin
            if (pop && hs) begin
              head_q <= fifo_data_i;
            end else if (pop) begin
              tail_q  <= fifo_data_i;
              state_q <= TWO;
            end else if (hs) begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
            end
          end
          TWO: begin
            if (hs) begin
              head_q  <= tail_q;
              state_q <= ONE;
            end
          end
          default: begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_pop_o  = pop;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign xfer_cnt_o  = xfer_q;
`ifdef LLC_RD_SKID_EN
  assign occupancy_o = state_q;
`else
  assign occupancy_o = {1'b0, state_q[0]};
`endif

endmodule

// File: tb/tb_llc_fifo_reader.sv
// Bench for llc_fifo_reader: a queue-based FIFO source plus a queue-based model of buffered words.
module tb_llc_fifo_reader;
`ifdef LLC_RD_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          ready = 1'b0;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [CW-1:0] xfer;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int exp_cnt = 0;
  int pops = 0;
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  llc_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_data_o(out_data),
    .occupancy_o(occ), .xfer_cnt_o(xfer)
  );

  function automatic logic m_pop();
    return (src_q.size() != 0) && !flush && (exp_q.size() < CAP);
  endfunction

  task automatic drive_src();
    fifo_empty = (src_q.size() == 0);
    fifo_data  = (src_q.size() != 0) ? src_q[0] : DW'($urandom());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
    src_q.delete(); exp_q.delete(); exp_cnt = 0; pops = 0;
    drive_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Advance one clock; the model retires, flushes and accepts words by the channel rules.
  task automatic tick();
    logic mpop, mhs, dpop, fl;
    mpop = m_pop();
    mhs  = (exp_q.size() != 0) && ready;
    dpop = fifo_pop;
    fl   = flush;
    @(posedge clk);
    if (mhs) begin void'(exp_q.pop_front()); exp_cnt++; end
    if (fl) exp_q.delete();
    if (mpop) exp_q.push_back(src_q[0]);
    if (dpop && src_q.size() != 0) begin void'(src_q.pop_front()); pops++; end
    if (fl) src_q.delete();
    #1 drive_src();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    vectors++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occ); end
    vectors++; if (xfer !== '0) begin errors++; $display("FAIL reset_xfer got=%0d exp=0", xfer); end
    vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    do_reset();
    vectors++; if ({fifo_pop, out_valid, occ} !== 4'b0) begin errors++; $display("FAIL reset_release got=%b exp=0000", {fifo_pop, out_valid, occ}); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got[$];
    int cyc[$];
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'hA0 + i));
    drive_src();
    ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (out_valid && ready) begin got.push_back(out_data); cyc.push_back(c); end
      vectors++; if (fifo_pop && occ >= 2'(CAP)) begin errors++; $display("FAIL b2b_pop_when_full cycle=%0d occ=%0d got=1 exp=0", c, occ); end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (k >= got.size()) begin
        errors++; $display("FAIL b2b_missing word=%0d got=none exp=%h", k, 32'hA0 + k);
      end else if (got[k] !== DW'(32'hA0 + k) || cyc[k] != ((CAP == 2) ? k + 1 : 2 * k + 1)) begin
        errors++; $display("FAIL b2b_word idx=%0d got=%h@%0d exp=%h@%0d", k, got[k], cyc[k], 32'hA0 + k, (CAP == 2) ? k + 1 : 2 * k + 1);
      end
    end
    vectors++; if (got.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
    vectors++; if (pops != 8) begin errors++; $display("FAIL b2b_pops got=%0d exp=8", pops); end
    vectors++; if (xfer !== CW'(8)) begin errors++; $display("FAIL b2b_xfer got=%0d exp=8", xfer); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] got[$];
    int cyc[$];
    logic [DW-1:0] want[3];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(want[i]);
    drive_src();
    ready = 1'b0;
    repeat (5) begin #1; tick(); end
    #1;
    vectors++; if (pops != CAP) begin errors++; $display("FAIL stall_pops got=%0d exp=%0d", pops, CAP); end
    vectors++; if (occ !== 2'(CAP)) begin errors++; $display("FAIL stall_occ got=%0d exp=%0d", occ, CAP); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL stall_head got=%b/%h exp=1/11", out_valid, out_data); end
    ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid && ready) begin got.push_back(out_data); cyc.push_back(c); end
      tick(); #1;
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (k >= got.size()) begin
        errors++; $display("FAIL stall_missing word=%0d got=none exp=%h", k, want[k]);
      end else if (got[k] !== want[k] || cyc[k] != ((CAP == 2) ? k : 2 * k)) begin
        errors++; $display("FAIL stall_word idx=%0d got=%h@%0d exp=%h@%0d", k, got[k], cyc[k], want[k], (CAP == 2) ? k : 2 * k);
      end
    end
    vectors++; if (got.size() != 3) begin errors++; $display("FAIL stall_count got=%0d exp=3", got.size()); end
  endtask

  task automatic test_flush();
    logic [CW-1:0] xb;
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom()));
    drive_src();
    flush = 1'b1;
    #1;
    vectors++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL flush_idle_pop got=%b exp=0", fifo_pop); end
    tick();
    flush = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL flush_idle_state got=%b/%0d exp=0/0", out_valid, occ); end
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom()));
    drive_src();
    repeat (3) begin #1; tick(); end
    #1;
    vectors++; if (occ !== 2'(CAP)) begin errors++; $display("FAIL flush_pre_occ got=%0d exp=%0d", occ, CAP); end
    xb = xfer;
    flush = 1'b1; ready = 1'b1;
    #1;
    vectors++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL flush_pop got=%b exp=0", fifo_pop); end
    tick();
    flush = 1'b0; ready = 1'b0;
    #1;
    vectors++; if (xfer !== CW'(xb + 1)) begin errors++; $display("FAIL flush_xfer got=%0d exp=%0d", xfer, CW'(xb + 1)); end
    vectors++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL flush_state got=%b/%0d exp=0/0", out_valid, occ); end
    src_q.push_back(32'h5A);
    drive_src();
    tick(); #1;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h5A || occ !== 2'd1) begin errors++; $display("FAIL flush_after got=%b/%h/%0d exp=1/5a/1", out_valid, out_data, occ); end
  endtask

  task automatic test_wrap();
    logic seen15, wrapped;
    seen15 = 1'b0; wrapped = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) src_q.push_back(DW'($urandom()));
    drive_src();
    ready = 1'b1;
    for (int c = 0; c < 60 && exp_cnt < 17; c++) begin
      #1;
      if (seen15 && xfer === '0) wrapped = 1'b1;
      seen15 = (xfer === 4'd15);
      tick();
    end
    #1;
    vectors++; if (!wrapped) begin errors++; $display("FAIL wrap_15_to_0 got=no_wrap exp=wrap"); end
    vectors++; if (xfer !== CW'(1)) begin errors++; $display("FAIL wrap_final got=%0d exp=1", xfer); end
    vectors++; if (pops != 17) begin errors++; $display("FAIL wrap_pops got=%0d exp=17", pops); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (src_q.size() < 6 && $urandom_range(0, 2) != 0) src_q.push_back(DW'($urandom()));
      drive_src();
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      #1;
      vectors++; if (fifo_pop !== m_pop()) begin errors++; $display("FAIL rnd_pop cycle=%0d got=%b exp=%b", c, fifo_pop, m_pop()); end
      vectors++; if (occ !== 2'(exp_q.size())) begin errors++; $display("FAIL rnd_occ cycle=%0d got=%0d exp=%0d", c, occ, exp_q.size()); end
      vectors++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cycle=%0d got=%b exp=%b", c, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        vectors++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data cycle=%0d got=%h exp=%h", c, out_data, exp_q[0]); end
      end
      vectors++; if (xfer !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd_xfer cycle=%0d got=%0d exp=%0d", c, xfer, CW'(exp_cnt)); end
      tick();
    end
    flush = 1'b0; ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) src_q.push_back(DW'($urandom()));
    drive_src();
    ready = 1'b1;
    repeat (2) begin #1; tick(); end
    ready = 1'b0;
    repeat (4) begin #1; tick(); end
    #1;
    vectors++; if (occ !== 2'(CAP) || xfer !== CW'(exp_cnt)) begin errors++; $display("FAIL arst_pre got=%0d/%0d exp=%0d/%0d", occ, xfer, CAP, CW'(exp_cnt)); end
    #2;
    rst_n = 1'b0;
    src_q.delete(); exp_q.delete(); exp_cnt = 0;
    drive_src();
    #1;
    vectors++; if (out_valid !== 1'b0 || occ !== 2'd0) begin errors++; $display("FAIL arst_state got=%b/%0d exp=0/0", out_valid, occ); end
    vectors++; if (xfer !== '0 || out_data !== '0) begin errors++; $display("FAIL arst_regs got=%0d/%h exp=0/0", xfer, out_data); end
    vectors++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL arst_pop got=%b exp=0", fifo_pop); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
